// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter serialising NCORES core data-memory ports onto one shared RAM port.
// Latency: request sampled in IDLE cycle t -> core_ack in cycle t+2+MEM_LAT; one access in flight at a time.
// Backpressure: a core holds rd/wr/addr/wdata until it sees core_ack; requests seen outside IDLE are ignored.
//
// Ports:
//   clk, rst_n             clock (rising edge) and asynchronous active-low reset
//   core_rd_i / core_wr_i  per-core read / write request, held until ack (rd+wr together = write)
//   core_addr_i            packed addresses, core i at [i*AW +: AW]
//   core_wdata_i           packed write data, core i at [i*DW +: DW]
//   core_lock_i            (DMEM_ARB_LOCK_EN only) keep ownership after this access completes
//   core_ack_o             one-hot single-cycle completion pulse
//   core_grant_o           one-hot owner of the access in flight, zero when idle
//   core_rdata_o           read data, broadcast, valid in the ack cycle and held afterwards
//   mem_addr_o/mem_wdata_o address / write data towards the RAM
//   mem_read_o/mem_write_o single-cycle RAM strobes, never both high
//   mem_rdata_i            RAM read data, valid MEM_LAT cycles after the read strobe edge
//
// Optional feature macro: DMEM_ARB_LOCK_EN adds core_lock_i, letting the owner keep the RAM
// across several accesses (atomic read-modify-write). Undefined: plain round robin.

module dmem_arbiter #(
    parameter int NCORES  = 2,
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int MEM_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCORES-1:0]    core_rd_i,
    input  logic [NCORES-1:0]    core_wr_i,
    input  logic [NCORES*AW-1:0] core_addr_i,
    input  logic [NCORES*DW-1:0] core_wdata_i,
`ifdef DMEM_ARB_LOCK_EN
    input  logic [NCORES-1:0]    core_lock_i,
`endif
    output logic [NCORES-1:0]    core_ack_o,
    output logic [NCORES-1:0]    core_grant_o,
    output logic [DW-1:0]        core_rdata_o,
    output logic [AW-1:0]        mem_addr_o,
    output logic [DW-1:0]        mem_wdata_o,
    output logic                 mem_read_o,
    output logic                 mem_write_o,
    input  logic [DW-1:0]        mem_rdata_i
);

    localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam int CW = IW + 1;
    localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            wr_q, wr_d;
    logic [LW-1:0]   lat_q, lat_d;
    logic [DW-1:0]   rdata_q, rdata_d;
`ifdef DMEM_ARB_LOCK_EN
    logic            lock_q, lock_d;
`endif

    logic [NCORES-1:0] req;
    logic [NCORES-1:0] eligible;
    logic [NCORES-1:0] idx_oh;
    logic              pick_vld;
    logic [IW-1:0]     pick_idx;
    logic [CW-1:0]     cand_w;
    logic [IW-1:0]     cand;

    assign req    = core_rd_i | core_wr_i;
    assign idx_oh = NCORES'(1) << idx_q;

`ifdef DMEM_ARB_LOCK_EN
    // While locked only the previous owner may win; idx_q still names it.
    assign eligible = lock_q ? (req & idx_oh) : req;
`else
    assign eligible = req;
`endif

    // Round-robin search starting at rr_ptr_q, wrapping modulo NCORES.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand_w   = '0;
        cand     = '0;
        for (int k = 0; k < NCORES; k++) begin
            cand_w = {1'b0, rr_ptr_q} + CW'(k);
            if (cand_w >= CW'(NCORES)) begin
                cand_w = cand_w - CW'(NCORES);
            end
            cand = cand_w[IW-1:0];
            if (!pick_vld && eligible[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rr_ptr_d = rr_ptr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wr_d     = wr_q;
        lat_d    = lat_q;
        rdata_d  = rdata_q;
`ifdef DMEM_ARB_LOCK_EN
        lock_d   = lock_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    idx_d   = pick_idx;
                    addr_d  = core_addr_i[int'(pick_idx)*AW +: AW];
                    wdata_d = core_wdata_i[int'(pick_idx)*DW +: DW];
                    // A write wins when both rd and wr are raised.
                    wr_d    = core_wr_i[pick_idx];
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                lat_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_q == LW'(MEM_LAT - 1)) begin
                    // Last WAIT cycle: RAM data is valid now.
                    if (!wr_q) begin
                        rdata_d = mem_rdata_i;
                    end
                    state_d = ST_RESP;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
`ifdef DMEM_ARB_LOCK_EN
                if (core_lock_i[idx_q]) begin
                    lock_d = 1'b1;
                end else begin
                    lock_d   = 1'b0;
                    rr_ptr_d = (idx_q == IW'(NCORES - 1)) ? '0 : idx_q + IW'(1);
                end
`else
                rr_ptr_d = (idx_q == IW'(NCORES - 1)) ? '0 : idx_q + IW'(1);
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            rr_ptr_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            lat_q    <= '0;
            rdata_q  <= '0;
`ifdef DMEM_ARB_LOCK_EN
            lock_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rr_ptr_q <= rr_ptr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wr_q     <= wr_d;
            lat_q    <= lat_d;
            rdata_q  <= rdata_d;
`ifdef DMEM_ARB_LOCK_EN
            lock_q   <= lock_d;
`endif
        end
    end

    // Outputs decode straight from registered state, so they are zero during reset.
    assign core_grant_o = (state_q != ST_IDLE) ? idx_oh : '0;
    assign core_ack_o   = (state_q == ST_RESP) ? idx_oh : '0;
    assign mem_read_o   = (state_q == ST_ACCESS) && !wr_q;
    assign mem_write_o  = (state_q == ST_ACCESS) && wr_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign core_rdata_o = rdata_q;

    a_ack_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(core_ack_o));
    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(core_grant_o));
    a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n) !(mem_read_o && mem_write_o));

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int N   = 2;
    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LAT = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // Main instance (MEM_LAT = 1)
    logic [N-1:0]    core_rd, core_wr, core_ack, core_grant;
    logic [N*AW-1:0] core_addr;
    logic [N*DW-1:0] core_wdata;
    logic [DW-1:0]   core_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]   mem_addr;
    logic            mem_read, mem_write;

    // Second instance (MEM_LAT = 3)
    logic [N-1:0]    d3_rd, d3_wr, d3_ack, d3_grant;
    logic [N*AW-1:0] d3_addr;
    logic [N*DW-1:0] d3_wdata;
    logic [DW-1:0]   d3_rdata, d3_mem_wdata, d3_mem_rdata;
    logic [AW-1:0]   d3_mem_addr;
    logic            d3_mem_read, d3_mem_write;

`ifdef DMEM_ARB_LOCK_EN
    logic [N-1:0] core_lock;
    logic [N-1:0] d3_lock;
`endif

    dmem_arbiter #(.NCORES(N), .AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_rd_i(core_rd), .core_wr_i(core_wr),
        .core_addr_i(core_addr), .core_wdata_i(core_wdata),
`ifdef DMEM_ARB_LOCK_EN
        .core_lock_i(core_lock),
`endif
        .core_ack_o(core_ack), .core_grant_o(core_grant), .core_rdata_o(core_rdata),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_rdata_i(mem_rdata)
    );

    dmem_arbiter #(.NCORES(N), .AW(AW), .DW(DW), .MEM_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .core_rd_i(d3_rd), .core_wr_i(d3_wr),
        .core_addr_i(d3_addr), .core_wdata_i(d3_wdata),
`ifdef DMEM_ARB_LOCK_EN
        .core_lock_i(d3_lock),
`endif
        .core_ack_o(d3_ack), .core_grant_o(d3_grant), .core_rdata_o(d3_rdata),
        .mem_addr_o(d3_mem_addr), .mem_wdata_o(d3_mem_wdata),
        .mem_read_o(d3_mem_read), .mem_write_o(d3_mem_write), .mem_rdata_i(d3_mem_rdata)
    );

    // Contents of never-written RAM locations
    function automatic logic [15:0] ram_default(input logic [7:0] a);
        return {a, ~a};
    endfunction

    // RAM stub for the main instance: 1-cycle read latency
    logic [15:0] ram [256];
    bit          ram_vld [256];
    logic [15:0] rp1;
    always @(posedge clk) begin
        if (mem_write) begin
            ram[mem_addr[7:0]]     <= mem_wdata;
            ram_vld[mem_addr[7:0]] <= 1'b1;
        end
        rp1 <= mem_read ? (ram_vld[mem_addr[7:0]] ? ram[mem_addr[7:0]] : ram_default(mem_addr[7:0])) : 16'h0;
    end
    assign mem_rdata = rp1;

    // Read-only RAM stub for the MEM_LAT=3 instance
    logic [15:0] d3p0, d3p1, d3p2;
    always @(posedge clk) begin
        d3p0 <= d3_mem_read ? ram_default(d3_mem_addr[7:0]) : 16'h0;
        d3p1 <= d3p0;
        d3p2 <= d3p1;
    end
    assign d3_mem_rdata = d3p2;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int c, input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d);
        core_rd[c]             = rd;
        core_wr[c]             = wr;
        core_addr[c*AW +: AW]  = a;
        core_wdata[c*DW +: DW] = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Ticks until an ack appears (bounded); counts RAM strobes seen on the way
    task automatic wait_ack(output int who, output int n, output int nrd, output int nwr);
        who = -1; n = 0; nrd = 0; nwr = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            nrd += int'(mem_read);
            nwr += int'(mem_write);
            if (core_ack != '0) begin
                n   = i;
                who = core_ack[1] ? 1 : 0;
                break;
            end
        end
    endtask

    typedef struct {
        int          core;
        bit          rd;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        int          exp_nrd;
        int          exp_nwr;
    } vec_t;

    vec_t tbl [7];

    // Higher-level reference model state
    bit          m_busy;
    int          m_start, m_owner, m_ptr;
    bit          m_wr;
    logic [15:0] m_addr, m_wdata, m_rdata;
    logic [15:0] m_mem [256];
    bit          m_vld [256];
    bit          act [N];
    bit          drop [N];
    int          gap [N];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int who, n, nrd, nwr;

        tbl[0] = '{0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 0, 1};
        tbl[1] = '{0, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1, 0};
        tbl[2] = '{1, 1'b0, 1'b1, 16'h0003, 16'h1234, 16'hBEEF, 0, 1};
        tbl[3] = '{1, 1'b1, 1'b0, 16'h0003, 16'h0000, 16'h1234, 1, 0};
        tbl[4] = '{0, 1'b1, 1'b1, 16'h0005, 16'h5555, 16'h1234, 0, 1};
        tbl[5] = '{1, 1'b1, 1'b0, 16'h0005, 16'h0000, 16'h5555, 1, 0};
        tbl[6] = '{0, 1'b1, 1'b0, 16'h0042, 16'h0000, 16'h42BD, 1, 0};

        core_rd = '0; core_wr = '0; core_addr = '0; core_wdata = '0;
        d3_rd = '0; d3_wr = '0; d3_addr = '0; d3_wdata = '0;
`ifdef DMEM_ARB_LOCK_EN
        core_lock = '0; d3_lock = '0;
`endif

        // Reset with requests active: everything quiet
        rst_n = 1'b0;
        set_req(0, 1'b1, 1'b0, 16'h1111, 16'h2222);
        set_req(1, 1'b0, 1'b1, 16'h3333, 16'h4444);
        tick(); tick();
        check("rst_ctl", {core_ack, core_grant, mem_read, mem_write}, 32'h0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_rdata", core_rdata, 32'h0);
        core_rd = '0; core_wr = '0;
        rst_n = 1'b1;
        tick();
        check("idle_grant", core_grant, 32'h0);

        // Table-driven single accesses
        for (int i = 0; i < 7; i++) begin
            set_req(tbl[i].core, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata);
            wait_ack(who, n, nrd, nwr);
            check($sformatf("tbl%0d_who", i), who, tbl[i].core);
            check($sformatf("tbl%0d_lat", i), n, 3);
            check($sformatf("tbl%0d_rdata", i), core_rdata, tbl[i].exp_rdata);
            check($sformatf("tbl%0d_nrd", i), nrd, tbl[i].exp_nrd);
            check($sformatf("tbl%0d_nwr", i), nwr, tbl[i].exp_nwr);
            tick();
            core_rd = '0; core_wr = '0;
            tick();
        end

        // Simultaneous requests held continuously: 0,1,0,1 with 3 then 4-cycle spacing
        do_reset();
        set_req(0, 1'b1, 1'b0, 16'h0020, 16'h0);
        set_req(1, 1'b1, 1'b0, 16'h0021, 16'h0);
        for (int i = 0; i < 4; i++) begin
            wait_ack(who, n, nrd, nwr);
            check($sformatf("rr%0d_who", i), who, i % 2);
            check($sformatf("rr%0d_lat", i), n, (i == 0) ? 3 : 4);
            check($sformatf("rr%0d_rdata", i), core_rdata, (i % 2 == 0) ? 32'h20DF : 32'h21DE);
        end
        tick();
        core_rd = '0;
        tick();

        // MEM_LAT=3 instance
        d3_rd[0] = 1'b1;
        d3_addr[15:0] = 16'h0007;
        n = 0; nrd = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            nrd += int'(d3_mem_read);
            if (d3_ack != '0) begin
                n = i;
                break;
            end
        end
        check("lat3_lat", n, 5);
        check("lat3_nrd", nrd, 1);
        check("lat3_rdata", d3_rdata, 32'h07F8);
        check("lat3_ack", d3_ack, 32'h1);
        tick();
        d3_rd = '0;
        tick();

        // Reset during WAIT of a core1 read
        do_reset();
        set_req(1, 1'b1, 1'b0, 16'h0030, 16'h0);
        tick(); tick();
        check("abort_pre_grant", core_grant, 32'h2);
        rst_n = 1'b0;
        #1;
        check("abort_ctl", {core_ack, core_grant, mem_read, mem_write}, 32'h0);
        check("abort_rdata", core_rdata, 32'h0);
        tick();
        set_req(0, 1'b1, 1'b0, 16'h0031, 16'h0);
        rst_n = 1'b1;
        wait_ack(who, n, nrd, nwr);
        check("abort_fresh_who", who, 0);
        check("abort_fresh_lat", n, 3);
        tick();
        core_rd[0] = 1'b0;
        wait_ack(who, n, nrd, nwr);
        check("abort_c1_who", who, 1);
        check("abort_c1_lat", n, 3);
        check("abort_c1_rdata", core_rdata, 32'h30CF);
        tick();
        core_rd = '0;
        tick();

`ifdef DMEM_ARB_LOCK_EN
        // Locked read-modify-write by core0 while core1 waits
        do_reset();
        core_lock[0] = 1'b1;
        set_req(0, 1'b1, 1'b0, 16'h0040, 16'h0);
        set_req(1, 1'b1, 1'b0, 16'h0041, 16'h0);
        wait_ack(who, n, nrd, nwr);
        check("lock_first_who", who, 0);
        tick();
        core_rd[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("lock_hold%0d_grant", i), core_grant, 32'h0);
        end
        core_lock[0] = 1'b0;
        set_req(0, 1'b0, 1'b1, 16'h0040, 16'h7777);
        wait_ack(who, n, nrd, nwr);
        check("lock_rmw_who", who, 0);
        tick();
        core_wr[0] = 1'b0;
        wait_ack(who, n, nrd, nwr);
        check("lock_c1_who", who, 1);
        check("lock_c1_lat", n, 3);
        check("lock_c1_rdata", core_rdata, 32'h41BE);
        tick();
        core_rd = '0;
        tick();
`endif

        // Randomised traffic against the transaction-level model
        do_reset();
        m_busy = 1'b0; m_ptr = 0; m_rdata = 16'h0; m_owner = 0; m_start = 0;
        m_wr = 1'b0; m_addr = '0; m_wdata = '0;
        for (int i = 0; i < N; i++) begin
            act[i] = 1'b0; drop[i] = 1'b0; gap[i] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [N-1:0] e_grant, e_ack, reqv;
            logic         e_rd, e_wr;
            bit           idle_now;
            int           off;
            tick();
            idle_now = !m_busy;
            e_grant = '0; e_ack = '0; e_rd = 1'b0; e_wr = 1'b0;
            if (m_busy) begin
                off = cyc - m_start;
                e_grant = N'(1) << m_owner;
                if (off == 1) begin
                    e_rd = !m_wr;
                    e_wr = m_wr;
                    check("rand_addr", mem_addr, m_addr);
                    if (m_wr) check("rand_wdata", mem_wdata, m_wdata);
                end
                if (off == 2 + LAT) begin
                    e_ack = N'(1) << m_owner;
                    if (m_wr) begin
                        m_mem[m_addr[7:0]] = m_wdata;
                        m_vld[m_addr[7:0]] = 1'b1;
                    end else begin
                        m_rdata = m_vld[m_addr[7:0]] ? m_mem[m_addr[7:0]] : ram_default(m_addr[7:0]);
                    end
                    m_busy = 1'b0;
                    m_ptr  = (m_owner + 1) % N;
                end
            end
            check("rand_ctl", {core_grant, core_ack, mem_read, mem_write}, {e_grant, e_ack, e_rd, e_wr});
            check("rand_rdata", core_rdata, m_rdata);

            // Core behaviour: hold until ack, drop the cycle after, idle a random gap
            for (int c = 0; c < N; c++) begin
                if (drop[c]) begin
                    drop[c] = 1'b0; act[c] = 1'b0;
                    core_rd[c] = 1'b0; core_wr[c] = 1'b0;
                    gap[c] = int'($urandom_range(0, 3));
                end else if (core_ack[c]) begin
                    drop[c] = 1'b1;
                end else if (!act[c]) begin
                    if (gap[c] > 0) begin
                        gap[c]--;
                    end else begin
                        int op;
                        op = int'($urandom_range(0, 2));
                        act[c] = 1'b1;
                        set_req(c, (op != 1), (op != 0), 16'h0080 + 16'($urandom_range(0, 31)), 16'($urandom));
                    end
                end
            end

            if (idle_now) begin
                reqv = core_rd | core_wr;
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_ptr + k) % N;
                    if (!m_busy && reqv[c]) begin
                        m_busy  = 1'b1;
                        m_owner = c;
                        m_start = cyc;
                        m_wr    = core_wr[c];
                        m_addr  = core_addr[c*AW +: AW];
                        m_wdata = core_wdata[c*DW +: DW];
                    end
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
